cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_sim_pkg.sv | 18 +
 rtl/pc_halt_det.sv | 43 ++++
 rtl/cpu_run_ctrl.sv | 98 +++++++++
 tb/tb_cpu_run_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sim_pkg.sv
// cpu_sim_pkg: shared run-controller state encoding and counter helpers
package cpu_sim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        DONE,
        TMO
    } state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pc_halt_det.sv
// pc_halt_det: counts consecutive identical valid PC samples and flags a self-loop halt
module pc_halt_det #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned HALT_REPEAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    input  logic            pc_valid,
    output logic            halt
);

    logic [PC_W-1:0] last_pc;
    logic [3:0]      cnt;
    logic [3:0]      cnt_inc;
    logic            seen;
    logic            match;

    // seen gates the compare so the first sample of a run never matches stale data
    assign match   = seen && (pc == last_pc);
    assign cnt_inc = cnt + 4'd1;
    assign halt    = en && pc_valid && match && (cnt_inc == 4'(HALT_REPEAT));

    // track the last valid PC and how many times in a row it has been seen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc <= '0;
            cnt     <= '0;
            seen    <= 1'b0;
        end else if (clear) begin
            last_pc <= '0;
            cnt     <= '0;
            seen    <= 1'b0;
        end else if (en && pc_valid) begin
            last_pc <= pc;
            cnt     <= match ? cnt_inc : 4'd1;
            seen    <= 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences CPU reset, run, halt detection and timeout for simulation
module cpu_run_ctrl
    import cpu_sim_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 5,
    parameter int unsigned PC_W        = 32,
    parameter logic [31:0] TIMEOUT     = 32'd10000,
    parameter int unsigned HALT_REPEAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PC_W-1:0] pc,
    input  logic            pc_valid,
    output logic            cpu_rst,
    output logic            running,
    output logic            done,
    output logic            timeout,
    output logic [31:0]     cycle_cnt,
    output logic [PC_W-1:0] halt_pc
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

    logic [1:0] sync;
    logic       rst_sync;
    state_t     state;
    state_t     state_nxt;
    logic [7:0] rst_cnt;
    logic       halt;
    logic       launch;
    logic       rst_end;
    logic       tmo_hit;

    // assert asynchronously, release two clocks after the external reset goes high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b00;
        else      sync <= {sync[0], 1'b1};
    end

    assign rst_sync = sync[1];
    assign launch   = start && (state == IDLE || state == DONE || state == TMO);
    assign rst_end  = (rst_cnt == RST_LAST);
    assign tmo_hit  = (cycle_cnt == TIMEOUT - 32'd1);

    // state register
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) state <= IDLE;
        else           state <= state_nxt;
    end

    // next state; a halt on the final timeout cycle takes priority over the timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, TMO: if (start) state_nxt = RESET;
            RESET:           if (rst_end) state_nxt = RUN;
            RUN:             state_nxt = halt ? DONE : (tmo_hit ? TMO : RUN);
            default:         state_nxt = IDLE;
        endcase
    end

    // reset-hold counter, run-cycle counter and halt PC capture
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            rst_cnt   <= '0;
            cycle_cnt <= '0;
            halt_pc   <= '0;
        end else if (launch) begin
            rst_cnt   <= '0;
            cycle_cnt <= '0;
        end else if (state == RESET) begin
            rst_cnt <= rst_cnt + 8'd1;
        end else if (state == RUN) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            if (halt) halt_pc <= pc;
        end
    end

    pc_halt_det #(
        .PC_W       (PC_W),
        .HALT_REPEAT(HALT_REPEAT)
    ) u_halt (
        .clk     (clk),
        .rst     (rst_sync),
        .clear   (launch),
        .en      (state == RUN),
        .pc      (pc),
        .pc_valid(pc_valid),
        .halt    (halt)
    );

    assign cpu_rst = (state != RUN);
    assign running = (state == RUN);
    assign done    = (state == DONE);
    assign timeout = (state == TMO);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scenario and randomized checks of cpu_run_ctrl against a run-level outcome model
module tb_cpu_run_ctrl;

    localparam int HR = 4;
    localparam int N  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;

    logic        cpu_rst, running, done, timeout;
    logic [31:0] cycle_cnt, halt_pc;
    logic        cpu_rst4, running4, done4, timeout4;
    logic [31:0] cycle_cnt4, halt_pc4;

    int total = 0;
    int bad = 0;

    cpu_run_ctrl #(.RST_CYCLES(5), .PC_W(32), .TIMEOUT(32'd20), .HALT_REPEAT(HR)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_valid(pc_valid),
        .cpu_rst(cpu_rst), .running(running), .done(done), .timeout(timeout),
        .cycle_cnt(cycle_cnt), .halt_pc(halt_pc)
    );

    cpu_run_ctrl #(.RST_CYCLES(5), .PC_W(32), .TIMEOUT(32'd4), .HALT_REPEAT(HR)) dut_short (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_valid(pc_valid),
        .cpu_rst(cpu_rst4), .running(running4), .done(done4), .timeout(timeout4),
        .cycle_cnt(cycle_cnt4), .halt_pc(halt_pc4)
    );

    always #5 clk = ~clk;

    // outcome of one run: halts when the last HR valid samples are all the same PC,
    // otherwise stops after `to` run cycles
    function automatic void predict(input int to, input logic [31:0] p [N], input bit v [N],
                                    output bit d, output int cyc, output logic [31:0] hpc);
        logic [31:0] hist [$];
        d = 1'b0;
        cyc = 0;
        hpc = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                hist.push_back(p[i]);
                if (hist.size() >= HR) begin
                    d = 1'b1;
                    for (int k = 1; k < HR; k++)
                        if (hist[hist.size() - 1 - k] != p[i]) d = 1'b0;
                    if (d) begin
                        cyc = i + 1;
                        hpc = p[i];
                        return;
                    end
                end
            end
            if (i + 1 == to) begin
                cyc = i + 1;
                return;
            end
        end
    endfunction

    task automatic do_run(input string name, input logic [31:0] p [N], input bit v [N], input bit poke);
        bit d20, d4;
        int c20, c4;
        logic [31:0] h20, h4;
        predict(20, p, v, d20, c20, h20);
        predict(4, p, v, d4, c4, h4);
        @(negedge clk);
        start = 1'b1;
        pc_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            total++;
            if ({running, cpu_rst, running4, cpu_rst4} !== 4'b0101) begin
                bad++;
                $display("FAIL %s reset_hold k=%0d: running/cpu_rst got %b%b %b%b want 01 01",
                         name, k, running, cpu_rst, running4, cpu_rst4);
            end
            pc = $urandom;
            pc_valid = 1'($urandom_range(0, 1));
            start = poke && (k == 2);
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if ({running, cpu_rst, running4, cpu_rst4} !== 4'b1010) begin
            bad++;
            $display("FAIL %s run_latency: running/cpu_rst got %b%b %b%b want 10 10",
                     name, running, cpu_rst, running4, cpu_rst4);
        end
        for (int i = 0; i < N; i++) begin
            pc = p[i];
            pc_valid = v[i];
            @(negedge clk);
        end
        for (int f = 0; f < 2; f++) begin
            total++;
            if ({running, done, timeout, cpu_rst} !== {1'b0, d20, !d20, 1'b1}) begin
                bad++;
                $display("FAIL %s status20 pass%0d: run/done/tmo/cpu_rst got %b%b%b%b want 0%b%b1",
                         name, f, running, done, timeout, cpu_rst, d20, !d20);
            end
            total++;
            if (cycle_cnt !== 32'(c20)) begin
                bad++;
                $display("FAIL %s cycle_cnt20 pass%0d: got %0d want %0d", name, f, cycle_cnt, c20);
            end
            if (d20) begin
                total++;
                if (halt_pc !== h20) begin
                    bad++;
                    $display("FAIL %s halt_pc20 pass%0d: got %h want %h", name, f, halt_pc, h20);
                end
            end
            total++;
            if ({running4, done4, timeout4, cpu_rst4} !== {1'b0, d4, !d4, 1'b1}) begin
                bad++;
                $display("FAIL %s status4 pass%0d: run/done/tmo/cpu_rst got %b%b%b%b want 0%b%b1",
                         name, f, running4, done4, timeout4, cpu_rst4, d4, !d4);
            end
            total++;
            if (cycle_cnt4 !== 32'(c4)) begin
                bad++;
                $display("FAIL %s cycle_cnt4 pass%0d: got %0d want %0d", name, f, cycle_cnt4, c4);
            end
            if (d4) begin
                total++;
                if (halt_pc4 !== h4) begin
                    bad++;
                    $display("FAIL %s halt_pc4 pass%0d: got %h want %h", name, f, halt_pc4, h4);
                end
            end
            for (int j = 0; j < 3; j++) begin
                pc = $urandom;
                pc_valid = 1'b1;
                @(negedge clk);
            end
        end
        pc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cpu_rst, running, done, timeout, cpu_rst4, running4, done4, timeout4} !== 8'b1000_1000) begin
            bad++;
            $display("FAIL reset_flags: got %b%b%b%b %b%b%b%b want 1000 1000",
                     cpu_rst, running, done, timeout, cpu_rst4, running4, done4, timeout4);
        end
        total++;
        if ({cycle_cnt, halt_pc, cycle_cnt4, halt_pc4} !== 128'd0) begin
            bad++;
            $display("FAIL reset_counts: cnt=%0d hpc=%h cnt4=%0d hpc4=%h want all 0",
                     cycle_cnt, halt_pc, cycle_cnt4, halt_pc4);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({cpu_rst, running, done, timeout} !== 4'b1000) begin
            bad++;
            $display("FAIL idle_after_release: got %b%b%b%b want 1000", cpu_rst, running, done, timeout);
        end
    endtask

    task automatic test_halt();
        logic [31:0] p [N];
        bit v [N];
        for (int i = 0; i < N; i++) begin
            p[i] = (i < 2) ? 32'(i * 4) : (i < 6 ? 32'h8 : 32'h100 + 32'(i * 4));
            v[i] = 1'b1;
        end
        do_run("halt_seq", p, v, 1'b0);
    endtask

    task automatic test_timeout();
        logic [31:0] p [N];
        bit v [N];
        for (int i = 0; i < N; i++) begin
            p[i] = 32'(i * 4);
            v[i] = 1'b1;
        end
        do_run("timeout_seq", p, v, 1'b0);
    endtask

    task automatic test_valid_toggle();
        logic [31:0] p [N];
        bit v [N];
        for (int i = 0; i < N; i++) begin
            p[i] = 32'h10;
            v[i] = (i % 2) == 0;
        end
        do_run("valid_toggle", p, v, 1'b0);
    endtask

    task automatic test_tie();
        logic [31:0] p [N];
        bit v [N];
        for (int i = 0; i < N; i++) begin
            p[i] = 32'h44;
            v[i] = 1'b1;
        end
        do_run("halt_tmo_tie", p, v, 1'b0);
    endtask

    task automatic test_no_stale();
        logic [31:0] p [N];
        bit v [N];
        for (int i = 0; i < N; i++) begin
            p[i] = (i < 3) ? 32'h44 : 32'h200 + 32'(i);
            v[i] = 1'b1;
        end
        do_run("no_stale", p, v, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] p [N];
        bit v [N];
        for (int i = 0; i < N; i++) begin
            p[i] = (i < 8) ? 32'(i * 8) : 32'h30;
            v[i] = 1'b1;
        end
        do_run("start_in_reset", p, v, 1'b1);
        do_run("restart", p, v, 1'b0);
    endtask

    task automatic test_mid_reset();
        logic [31:0] p [N];
        bit v [N];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pc = 32'h1000 + 32'(i * 4);
            pc_valid = 1'b1;
            @(negedge clk);
        end
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_pre: running got %b want 1", running);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({cpu_rst, running, done, timeout} !== 4'b1000) begin
            bad++;
            $display("FAIL mid_reset_flags: got %b%b%b%b want 1000", cpu_rst, running, done, timeout);
        end
        total++;
        if ({cycle_cnt, halt_pc, cycle_cnt4, halt_pc4} !== 128'd0) begin
            bad++;
            $display("FAIL mid_reset_counts: cnt=%0d hpc=%h cnt4=%0d hpc4=%h want all 0",
                     cycle_cnt, halt_pc, cycle_cnt4, halt_pc4);
        end
        pc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            p[i] = (i < 4) ? 32'h1000 : 32'h0;
            v[i] = 1'b1;
        end
        do_run("after_mid_reset", p, v, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] p [N];
        bit v [N];
        for (int r = 0; r < 12; r++) begin
            p[0] = 32'($urandom_range(0, 3) * 4);
            v[0] = $urandom_range(0, 3) != 0;
            for (int i = 1; i < N; i++) begin
                p[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3) * 4) : p[i - 1];
                v[i] = $urandom_range(0, 3) != 0;
            end
            do_run($sformatf("random%0d", r), p, v, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_timeout();
        test_valid_toggle();
        test_tie();
        test_no_stale();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
